// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: a - b, LSB first, one bit per clock behind a start/done handshake.
// Optional zero flag output enabled by defining SERIAL_SUB_ZERO_FLAG_EN.
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a_in,
    input  logic [WIDTH-1:0] i_b_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    output logic             o_zero
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WIDTH-1:0]  r_sh_a;
    logic [WIDTH-1:0]  r_sh_b;
    logic [WIDTH-1:0]  r_res;
    logic [WIDTH-1:0]  r_diff;
    logic [CntW-1:0]   r_cnt;
    logic              r_br;
    logic              r_borrow;

    logic              w_accept;
    logic              w_last;
    logic              w_a0;
    logic              w_b0;
    logic              w_d1;
    logic              w_bo1;
    logic              w_d;
    logic              w_bo2;
    logic              w_br_nxt;

    assign w_accept = (r_state == StIdle) && i_start;
    assign w_last   = (r_cnt == CntW'(WIDTH - 1));

    // Two cascaded half-subtractors; the second folds in the registered borrow.
    assign w_a0     = r_sh_a[0];
    assign w_b0     = r_sh_b[0];
    assign w_d1     = w_a0 ^ w_b0;
    assign w_bo1    = ~w_a0 & w_b0;
    assign w_d      = w_d1 ^ r_br;
    assign w_bo2    = ~w_d1 & r_br;
    assign w_br_nxt = w_bo1 | w_bo2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                o_done      = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_sh_a <= i_a_in;
            r_sh_b <= i_b_in;
            r_res  <= '0;
            r_cnt  <= '0;
            r_br   <= 1'b0;
        end else if (r_state == StRun) begin
            r_sh_a <= r_sh_a >> 1;
            r_sh_b <= r_sh_b >> 1;
            r_res  <= {w_d, r_res[WIDTH-1:1]};
            r_cnt  <= r_cnt + CntW'(1);
            r_br   <= w_br_nxt;
            // Publish on the final bit so results appear together with done.
            if (w_last) begin
                r_diff   <= {w_d, r_res[WIDTH-1:1]};
                r_borrow <= w_br_nxt;
            end
        end
    end

    assign o_diff       = r_diff;
    assign o_borrow_out = r_borrow;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic r_nz;
    logic r_zero;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_nz   <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_nz <= 1'b0;
        end else if (r_state == StRun) begin
            r_nz <= r_nz | w_d;
            if (w_last) begin
                r_zero <= ~(r_nz | w_d);
            end
        end
    end

    assign o_zero = r_zero;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomised self-checking bench for serial_sub_ctrl against an arithmetic reference model.
module tb_serial_sub_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic         zero;
`endif

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic [W-1:0] prev_diff = '0;
    logic         prev_brw = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub_ctrl #(.WIDTH(W)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_a_in       (a_in),
        .i_b_in       (b_in),
        .o_busy       (busy),
        .o_done       (done),
        .o_diff       (diff),
        .o_borrow_out (borrow_out)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        ,
        .o_zero       (zero)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle stamp at which done was seen; a timeout is a failed compare.
    task automatic wait_done(input string tag, output int at);
        tick();
        for (int k = 0; k < 4 * W && !done; k++) tick();
        check_val({tag, "_seen"}, done, 1);
        at = cyc;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        logic [W-1:0] e_diff;
        logic         e_brw;
        e_diff = a - b;
        e_brw  = (a < b);
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        tick();
        start  = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        for (int i = 1; i <= W; i++) begin
            check_val("run_busy", busy, 1);
            check_val("run_done_low", done, 0);
            check_val("run_diff_hold", diff, prev_diff);
            check_val("run_brw_hold", borrow_out, prev_brw);
            start = poke && (i == 3);
            tick();
        end
        start = 1'b0;
        check_val("done_pulse", done, 1);
        check_val("done_busy_low", busy, 0);
        check_val("diff", diff, e_diff);
        check_val("borrow", borrow_out, e_brw);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        check_val("zero", zero, (e_diff == '0));
`endif
        prev_diff = e_diff;
        prev_brw  = e_brw;
        tick();
        check_val("done_single", done, 0);
        check_val("idle_diff_hold", diff, prev_diff);
    endtask

    initial begin
        int t1;
        int t2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        tick();
        tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_diff", diff, 0);
        check_val("rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        check_val("rst_zero", zero, 0);
`endif
        rst = 1'b0;
        tick();

        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h03, 8'h05, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("idle_hold_fe", diff, 8'hFE);
        end
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'hFF, 8'h00, 1'b0);
        run_op(8'hA5, 8'hA5, 1'b0);
        run_op(8'h80, 8'h7F, 1'b1);
        for (int i = 0; i < W + 2; i++) begin
            check_val("poke_no_extra_done", done, 0);
            tick();
        end

        // start held high: back-to-back operations
        start = 1'b1;
        a_in  = 8'h10;
        b_in  = 8'h01;
        tick();
        a_in  = 8'h01;
        b_in  = 8'h10;
        wait_done("held1", t1);
        check_val("held1_diff", diff, 8'h0F);
        check_val("held1_borrow", borrow_out, 0);
        wait_done("held2", t2);
        start = 1'b0;
        check_val("held_period", t2 - t1, W + 2);
        check_val("held2_diff", diff, 8'hF1);
        check_val("held2_borrow", borrow_out, 1);
        prev_diff = 8'hF1;
        prev_brw  = 1'b1;
        tick();
        tick();
        check_val("held_idle_busy", busy, 0);

        // reset in RUN cycle 4 aborts the operation
        run_op(8'h05, 8'h03, 1'b0);
        start = 1'b1;
        a_in  = 8'h20;
        b_in  = 8'h01;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_diff", diff, 0);
        check_val("abort_borrow", borrow_out, 0);
        prev_diff = '0;
        prev_brw  = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check_val("abort_no_done", done, 0);
        end
        run_op(8'h20, 8'h01, 1'b0);

        for (int n = 0; n < 30; n++) begin
            ra = W'($urandom);
            rb = (n % 5 == 0) ? ra : W'($urandom);
            run_op(ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction controller: accepts two WIDTH-bit unsigned operands and computes a - b, LSB first, one bit per clock.
- Each bit slice is two cascaded half-subtractor stages plus a registered borrow flop.
- The FSM sequences the operand shift registers, bit counter, borrow flop and result capture behind a start/done handshake.
- Sits between a register-mapped host and the small-area arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  minuend; captured on the accepting edge
- b_in  input  WIDTH  subtrahend; captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse; result valid
- diff  output  WIDTH  (a - b) mod 2^WIDTH; held until the next DONE
- borrow_out  output  1  final borrow; 1 iff a < b unsigned
- zero  output  1  diff == 0; present only with SERIAL_SUB_ZERO_FLAG_EN

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-high (rst).
  - rst has priority over all other inputs.
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, borrow_out = 0, zero = 0.
  - Internal shift registers, counter and borrow flop = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at edge E0: load sh_a <- a_in, sh_b <- b_in, clear borrow flop br, clear cnt; next state RUN.
  - start = 0: remain in IDLE.
- RUN (busy = 1): at each edge, with a0 = sh_a[0], b0 = sh_b[0]:
  - Stage 1: d1 = a0 ^ b0, bo1 = ~a0 & b0.
  - Stage 2: d = d1 ^ br, bo2 = ~d1 & br.
  - br <- bo1 | bo2.
  - d is shifted into the MSB of the result register (result shifts right).
  - sh_a and sh_b shift right by 1; cnt increments.
  - Bits are processed at edges E1..E_WIDTH.
  - At the edge where cnt == WIDTH-1, next state is DONE.
- DONE (one cycle):
  - done = 1, busy = 0.
  - diff and borrow_out are registered on the RUN->DONE edge, so they are valid in the same cycle done is high.
  - Next state is IDLE unconditionally.
- Latency:
  - done is high in cycle WIDTH+1 after the accepting edge E0.
  - Minimum start-to-start period is WIDTH+2 cycles.
- start handling:
  - start is ignored in RUN and DONE; no queueing.
  - If start is held high continuously, a new operation is accepted on the first IDLE cycle after DONE.
- Output stability:
  - diff and borrow_out do not change during RUN; they hold the previous result.
  - They update only on the RUN->DONE edge.
- a_in and b_in are don't-care except at the accepting edge.
- Reset mid-operation (RUN or DONE):
  - Next cycle is IDLE with all reset values, including diff = 0.
  - No done pulse is issued for the aborted operation.
- Counter width is clog2(WIDTH); wrap-around is never reached because the FSM exits RUN at WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUB_ZERO_FLAG_EN.
- Defined:
  - Port zero exists.
  - A sticky internal flag nz is cleared on accept and ORed with each d during RUN.
  - zero <- ~nz is registered with diff on the RUN->DONE edge and held with diff.
  - zero resets to 0.
- Undefined:
  - Port zero and nz logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH = 8, a = 0x05, b = 0x03, start pulse at E0 -> busy cycles 1-8; done = 1 in cycle 9 only; diff = 0x02, borrow_out = 0.
- a = 0x03, b = 0x05 -> diff = 0xFE, borrow_out = 1; diff stays 0xFE through idle cycles until the next DONE.
- a = 0x00, b = 0x01 (borrow ripples through all bits) -> diff = 0xFF, borrow_out = 1. a = 0xFF, b = 0x00 -> diff = 0xFF, borrow_out = 0.
- a = b = 0xA5 -> diff = 0x00, borrow_out = 0, zero = 1 (macro on). Then a = 0x80, b = 0x7F -> diff = 0x01, zero = 0.
- start held high continuously with operands 0x10/0x01 then 0x01/0x10 -> done pulses exactly 10 cycles apart; results 0x0F/0 then 0xF1/1. start pulsed during RUN -> ignored, no extra done.
- Complete op giving diff = 0x02. Start 0x20/0x01, assert rst in RUN cycle 4 -> next cycle busy = 0, diff = 0, borrow_out = 0, no done. New op 0x20/0x01 -> diff = 0x1F, borrow_out = 0.
